mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none; block size fixed at 8 bytes, RAM fixed byte-wide with 1-cycle read latency.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rdy  in  1  global enable; when low, all registers hold and mem_wr SHALL be 0.
REQ-005 mem_din  in  8  RAM read data for address driven previous cycle.
REQ-006 mem_dout  out  8  RAM write data.
REQ-007 mem_a  out  32  RAM byte address.
REQ-008 mem_wr  out  1  RAM write strobe (1=write).
REQ-009 io_buffer_full  in  1  IO output buffer full.
REQ-010 ic_en  in  1  icache block request; held until ic_valid.
REQ-011 ic_addr  in  32  block address, bits[2:0]=000.
REQ-012 ic_valid  out  1  one-cycle pulse, ic_blk valid.
REQ-013 ic_blk  out  64  block, little-endian (byte i at bits[8i+7:8i]).
REQ-014 ls_en, ls_wr  in  1 each  load/store request (held until ls_valid); ls_wr=1 store.
REQ-015 ls_addr  in  32; ls_len  in  2 (00 byte, 01 half, 10 word; 11 treated as word); ls_wdata  in  32.
REQ-016 ls_valid  out  1  one-cycle completion pulse; ls_rdata  out  32  load data, zero-extended.
REQ-017 flush  in  1  abort in-progress instruction fetch.

Function
REQ-018 States SHALL be IDLE, IC_RD, LS_RD, LS_WR, DONE.
REQ-019 Acceptance only in IDLE; ls_en has priority over ic_en when both high.
REQ-020 Cycle 0 = first cycle after acceptance edge; n = byte count (8 for icache, 1/2/4 for ls_len).
REQ-021 Reads: mem_a=base+i, mem_wr=0 in cycle i (i=0..n-1); byte i captured from mem_din at end of cycle i+1; valid high in cycle n+1.
REQ-022 Writes: mem_a=base+i, mem_dout=ls_wdata[8i+7:8i], mem_wr=1 in cycle i; ls_valid high in cycle n.
REQ-023 Valid cycle is state DONE; no new request accepted in DONE; return to IDLE next cycle.
REQ-024 In IDLE: mem_wr=0, mem_a=0.
REQ-025 ls_rdata unused upper bytes SHALL be 0; ic_blk/ls_rdata hold last value until next completion.
REQ-026 flush high while in IC_RD: go to IDLE next edge, no ic_valid; flush in IDLE blocks ic_en acceptance that cycle; flush never affects LS_RD/LS_WR.
REQ-027 rdy low mid-transaction: byte index, state and captured data frozen; sequence resumes unchanged when rdy returns; a read byte address is re-driven before its data is captured.

Reset
REQ-028 rst high at a clock edge: state IDLE, mem_wr=0, mem_a=0, mem_dout=0, ic_valid=0, ls_valid=0, ic_blk=0, ls_rdata=0, byte index 0; applies mid-transaction, abandoning it with no valid pulse.

Configuration
REQ-029 Macro MEMCTRL_IO_STALL_EN defined: in LS_WR, if ls_addr[17:16]==2'b11 and io_buffer_full=1, mem_wr=0 and byte index holds that cycle; write resumes when io_buffer_full=0.
REQ-030 Macro undefined: io_buffer_full ignored; writes proceed per REQ-022.

Verification
REQ-031 RAM 0x1000..0x1007 = 00..07, ic_en addr 0x00001000 -> mem_a 0x1000..0x1007 in cycles 0..7, ic_valid only in cycle 9, ic_blk=0x0706050403020100.
REQ-032 Store word 0xDEADBEEF to 0x2000 -> mem_wr=1 cycles 0..3 writing EF,BE,AD,DE to 0x2000..0x2003, ls_valid in cycle 4.
REQ-033 ic_en (0x1000) and half load 0x2002 same cycle -> load served first, ls_rdata=0x0000DEAD; icache accepted after DONE, ic_blk as REQ-031.
REQ-034 flush asserted in cycle 3 of icache fetch -> no ic_valid, state IDLE, mem_a=0 next cycle; following ls_en accepted normally.
REQ-035 MEMCTRL_IO_STALL_EN defined, store byte 0x41 to 0x00030000, io_buffer_full high 3 cycles -> mem_wr=0 for those cycles, then one write of 0x41, ls_valid next cycle; macro undefined -> write in cycle 0.
REQ-036 rst asserted in cycle 1 of word store -> next cycle mem_wr=0, no ls_valid, all outputs at REQ-028 values.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM sequencer serving instruction-cache block fills
// and load/store accesses from a single synchronous RAM.
//
// The RAM is byte-wide with a one-cycle read latency: mem_din carries the
// byte for the address driven in the previous cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register and mem_wr
//   mem_din             RAM read data
//   mem_dout, mem_a     RAM write data / byte address
//   mem_wr              RAM write strobe
//   io_buffer_full      IO output buffer full (only used with the stall option)
//   ic_en, ic_addr      icache 8-byte block request (held until ic_valid)
//   ic_valid, ic_blk    one-cycle completion pulse, little-endian block
//   ls_en, ls_wr        load/store request (held until ls_valid), 1 = store
//   ls_addr, ls_len     byte address, size (00 byte, 01 half, 10/11 word)
//   ls_wdata            store data
//   ls_valid, ls_rdata  one-cycle completion pulse, zero-extended load data
//   flush               abort an in-progress instruction fetch
//
// Build option
//   MEMCTRL_IO_STALL_EN  when defined, stores into the IO window
//                        (ls_addr[17:16] == 2'b11) pause while io_buffer_full.

module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        ic_en,
  input  logic [31:0] ic_addr,
  output logic        ic_valid,
  output logic [63:0] ic_blk,
  input  logic        ls_en,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  input  logic        flush
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StIcRd = 3'd1;
  localparam logic [2:0] StLsRd = 3'd2;
  localparam logic [2:0] StLsWr = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;      // byte index within the transfer
  logic [3:0]  cnt_q, cnt_d;      // transfer length in bytes
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_ic_q, is_ic_d;
  logic [63:0] buf_q, buf_d;      // read bytes being assembled
  logic [63:0] ic_blk_q, ic_blk_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        io_stall;
  logic [3:0]  prev_idx;
  logic [5:0]  rd_off;
  logic [3:0]  addr_idx;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = (state_q == StLsWr) && (base_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  assign prev_idx = idx_q - 4'd1;
  assign rd_off   = {prev_idx[2:0], 3'b000};

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    is_ic_d    = is_ic_q;
    buf_d      = buf_q;
    ic_blk_d   = ic_blk_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      StIdle: begin
        if (ls_en) begin
          base_d  = ls_addr;
          wdata_d = ls_wdata;
          is_ic_d = 1'b0;
          idx_d   = 4'd0;
          buf_d   = 64'd0;
          case (ls_len)
            2'b00:   cnt_d = 4'd1;
            2'b01:   cnt_d = 4'd2;
            default: cnt_d = 4'd4;
          endcase
          state_d = ls_wr ? StLsWr : StLsRd;
        end else if (ic_en && !flush) begin
          base_d  = ic_addr;
          is_ic_d = 1'b1;
          idx_d   = 4'd0;
          cnt_d   = 4'd8;
          buf_d   = 64'd0;
          state_d = StIcRd;
        end
      end

      StIcRd, StLsRd: begin
        if ((state_q == StIcRd) && flush) begin
          state_d = StIdle;
          idx_d   = 4'd0;
        end else begin
          // Data for the byte addressed last cycle arrives now.
          if (idx_q != 4'd0) begin
            buf_d[rd_off +: 8] = mem_din;
          end
          if (idx_q == cnt_q) begin
            state_d = StDone;
            if (is_ic_q) begin
              ic_blk_d = buf_d;
            end else begin
              ls_rdata_d = buf_d[31:0];
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      StLsWr: begin
        if (!io_stall) begin
          if (idx_q == cnt_q - 4'd1) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        idx_d   = 4'd0;
      end

      default: begin
        state_d = StIdle;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      cnt_q      <= 4'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      is_ic_q    <= 1'b0;
      buf_q      <= 64'd0;
      ic_blk_q   <= 64'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      is_ic_q    <= is_ic_d;
      buf_q      <= buf_d;
      ic_blk_q   <= ic_blk_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // While a read is frozen, keep driving the address whose byte is captured
  // next, so mem_din holds that byte when rdy returns.
  always_comb begin
    if (!rdy && (idx_q != 4'd0)) begin
      addr_idx = prev_idx;
    end else begin
      addr_idx = idx_q;
    end
  end

  always_comb begin
    mem_a    = 32'd0;
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    case (state_q)
      StIcRd, StLsRd: begin
        mem_a = base_q + {28'd0, addr_idx};
      end
      StLsWr: begin
        mem_a    = base_q + {28'd0, idx_q};
        mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !io_stall;
      end
      default: begin
        mem_a = 32'd0;
      end
    endcase
  end

  assign ic_valid = (state_q == StDone) && is_ic_q && rdy;
  assign ls_valid = (state_q == StDone) && !is_ic_q && rdy;
  assign ic_blk   = ic_blk_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model (1-cycle read).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        ic_en;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [63:0] ic_blk;
  logic        ls_en;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_len;
  logic [31:0] ls_wdata;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic        flush;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ram [0:262143];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .ic_en          (ic_en),
    .ic_addr        (ic_addr),
    .ic_valid       (ic_valid),
    .ic_blk         (ic_blk),
    .ls_en          (ls_en),
    .ls_wr          (ls_wr),
    .ls_addr        (ls_addr),
    .ls_len         (ls_len),
    .ls_wdata       (ls_wdata),
    .ls_valid       (ls_valid),
    .ls_rdata       (ls_rdata),
    .flush          (flush)
  );

  // RAM model: write on strobe, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] wb [0:3];
    logic [7:0] hb [0:1];

    for (int a = 0; a < 262144; a++) ram[a] = 8'h00;
    for (int a = 0; a < 8; a++) begin
      ram[18'h1000 + a] = 8'(a);
      ram[18'h1008 + a] = 8'(8'h10 + a);
    end

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    ic_en = 1'b0; ic_addr = 32'd0;
    ls_en = 1'b0; ls_wr = 1'b0; ls_addr = 32'd0; ls_len = 2'b00; ls_wdata = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst mem_wr", mem_wr, 0);
    check("rst mem_a", mem_a, 0);
    check("rst mem_dout", mem_dout, 0);
    check("rst ic_valid", ic_valid, 0);
    check("rst ls_valid", ls_valid, 0);
    check("rst ic_blk", ic_blk, 0);
    check("rst ls_rdata", ls_rdata, 0);

    // Icache fill from 0x1000.
    tick();
    ic_en = 1'b1; ic_addr = 32'h1000;
    tick();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) check("ic mem_a", mem_a, 32'h1000 + c);
      check("ic mem_wr", mem_wr, 0);
      check("ic ic_valid", ic_valid, (c == 9));
      if (c == 9) begin
        check("ic ic_blk", ic_blk, 64'h0706050403020100);
        ic_en = 1'b0;
      end
      tick();
    end
    @(negedge clk);
    check("idle mem_a", mem_a, 0);

    // Word store 0xDEADBEEF to 0x2000.
    wb[0] = 8'hEF; wb[1] = 8'hBE; wb[2] = 8'hAD; wb[3] = 8'hDE;
    tick();
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2000; ls_len = 2'b10; ls_wdata = 32'hDEADBEEF;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("st mem_wr", mem_wr, (c < 4));
      check("st ls_valid", ls_valid, (c == 4));
      if (c < 4) begin
        check("st mem_a", mem_a, 32'h2000 + c);
        check("st mem_dout", mem_dout, wb[c]);
      end else begin
        ls_en = 1'b0;
      end
      tick();
    end
    check("st ram", {ram[18'h2003], ram[18'h2002], ram[18'h2001], ram[18'h2000]}, 32'hDEADBEEF);

    // Simultaneous icache and half load: load first, then icache.
    ic_en = 1'b1; ic_addr = 32'h1000;
    ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2002; ls_len = 2'b01;
    tick();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c < 2) check("pri ld mem_a", mem_a, 32'h2002 + c);
      check("pri ls_valid", ls_valid, (c == 3));
      check("pri ic_valid", ic_valid, (c == 14));
      if (c == 3) begin
        check("pri ls_rdata", ls_rdata, 32'h0000DEAD);
        ls_en = 1'b0;
      end
      if (c >= 5 && c < 13) check("pri ic mem_a", mem_a, 32'h1000 + (c - 5));
      if (c == 14) begin
        check("pri ic_blk", ic_blk, 64'h0706050403020100);
        ic_en = 1'b0;
      end
      tick();
    end

    // Icache fill from 0x1008 with rdy low in cycles 3 and 4.
    ic_en = 1'b1; ic_addr = 32'h1008;
    tick();
    for (int c = 0; c < 12; c++) begin
      rdy = !(c == 3 || c == 4);
      @(negedge clk);
      if (c < 3) check("stall mem_a", mem_a, 32'h1008 + c);
      if (c >= 5 && c < 10) check("stall mem_a", mem_a, 32'h1008 + (c - 2));
      check("stall ic_valid", ic_valid, (c == 11));
      check("stall mem_wr", mem_wr, 0);
      if (c < 11) check("stall blk hold", ic_blk, 64'h0706050403020100);
      if (c == 11) begin
        check("stall ic_blk", ic_blk, 64'h1716151413121110);
        ic_en = 1'b0;
      end
      tick();
    end
    rdy = 1'b1;

    // Flush in cycle 3 of a fetch, then a byte load from 0x2000.
    ic_en = 1'b1; ic_addr = 32'h1000;
    tick();
    for (int c = 0; c < 8; c++) begin
      if (c == 3) flush = 1'b1;
      if (c == 4) begin
        flush = 1'b0; ic_en = 1'b0;
        ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2000; ls_len = 2'b00;
      end
      @(negedge clk);
      if (c < 4) check("fl mem_a", mem_a, 32'h1000 + c);
      if (c == 4) check("fl idle mem_a", mem_a, 0);
      if (c == 5) check("fl ld mem_a", mem_a, 32'h2000);
      check("fl ic_valid", ic_valid, 0);
      check("fl ls_valid", ls_valid, (c == 7));
      if (c == 7) begin
        check("fl ls_rdata", ls_rdata, 32'h000000EF);
        check("fl ic_blk", ic_blk, 64'h1716151413121110);
        ls_en = 1'b0;
      end
      tick();
    end

    // Half store 0xCAFE to 0x2010 with rdy low in cycle 1.
    hb[0] = 8'hFE; hb[1] = 8'hCA;
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2010; ls_len = 2'b01; ls_wdata = 32'h1234CAFE;
    tick();
    for (int c = 0; c < 4; c++) begin
      rdy = (c != 1);
      @(negedge clk);
      check("hs mem_wr", mem_wr, (c == 0 || c == 2));
      check("hs ls_valid", ls_valid, (c == 3));
      if (c == 0) check("hs mem_dout", mem_dout, hb[0]);
      if (c == 2) begin
        check("hs mem_a", mem_a, 32'h2011);
        check("hs mem_dout", mem_dout, hb[1]);
      end
      if (c == 3) ls_en = 1'b0;
      tick();
    end
    rdy = 1'b1;

    // Byte store 0x41 into the IO window with io_buffer_full high 3 cycles.
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h00030000; ls_len = 2'b00; ls_wdata = 32'h00000041;
    tick();
    for (int c = 0; c < 5; c++) begin
      io_buffer_full = (c < 3);
      @(negedge clk);
`ifdef MEMCTRL_IO_STALL_EN
      check("io mem_wr", mem_wr, (c == 3));
      check("io ls_valid", ls_valid, (c == 4));
      if (c == 3) check("io mem_dout", mem_dout, 8'h41);
      if (c == 4) ls_en = 1'b0;
`else
      check("io mem_wr", mem_wr, (c == 0));
      check("io ls_valid", ls_valid, (c == 1));
      if (c == 0) check("io mem_dout", mem_dout, 8'h41);
      if (c == 1) ls_en = 1'b0;
`endif
      tick();
    end
    io_buffer_full = 1'b0;
    check("io ram", ram[18'h30000], 8'h41);

    // Reset in cycle 1 of a word store.
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2020; ls_len = 2'b10; ls_wdata = 32'h11223344;
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c == 1) rst = 1'b1;
      if (c == 2) begin
        rst = 1'b0; ls_en = 1'b0;
      end
      @(negedge clk);
      if (c == 0) check("rs mem_wr c0", mem_wr, 1);
      if (c == 2) begin
        check("rs mem_wr", mem_wr, 0);
        check("rs mem_a", mem_a, 0);
        check("rs mem_dout", mem_dout, 0);
        check("rs ic_blk", ic_blk, 0);
        check("rs ls_rdata", ls_rdata, 0);
        check("rs ic_valid", ic_valid, 0);
      end
      if (c >= 2) check("rs ls_valid", ls_valid, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
